// File: rtl/regf_writeback.sv
// Register-file write-port driver: buffers ALU/FPU/MEM results in per-source FIFOs and
// serialises them round-robin onto a single registered write port, exporting a pending mask.
module regf_writeback #(
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        i_alu_valid,
  output logic        o_alu_ready,
  input  logic [4:0]  i_alu_rd,
  input  logic [31:0] i_alu_data,
  input  logic        i_fpu_valid,
  output logic        o_fpu_ready,
  input  logic [4:0]  i_fpu_rd,
  input  logic [31:0] i_fpu_data,
  input  logic        i_mem_valid,
  output logic        o_mem_ready,
  input  logic [4:0]  i_mem_rd,
  input  logic [31:0] i_mem_data,
  output logic        o_w_enable,
  output logic [4:0]  o_w_addr,
  output logic [31:0] o_w_data,
  output logic [31:0] o_pending
);

  localparam int unsigned PW   = $clog2(BUF_DEPTH);
  localparam int unsigned NSRC = 3;

  // Source index: 0 = ALU, 1 = FPU, 2 = MEM
  logic [4:0]           r_rd   [NSRC][BUF_DEPTH];
  logic [31:0]          r_data [NSRC][BUF_DEPTH];
  logic [BUF_DEPTH-1:0] r_vld  [NSRC];
  logic [PW-1:0]        r_wptr [NSRC];
  logic [PW-1:0]        r_rptr [NSRC];
  logic [PW:0]          r_cnt  [NSRC];
  logic [1:0]           r_last;
  logic                 r_w_enable;
  logic [4:0]           r_w_addr;
  logic [31:0]          r_w_data;

  logic [NSRC-1:0] w_in_valid;
  logic [4:0]      w_in_rd   [NSRC];
  logic [31:0]     w_in_data [NSRC];
  logic [NSRC-1:0] w_ready;
  logic [NSRC-1:0] w_push;
  logic [NSRC-1:0] w_pop;
  logic [NSRC-1:0] w_nempty;
  logic            w_gnt_vld;
  logic [1:0]      w_gnt;
  logic [1:0]      w_cand;
  logic [31:0]     w_pend;

  function automatic logic [1:0] next_src(input logic [1:0] s);
    return (s == 2'd2) ? 2'd0 : s + 2'd1;
  endfunction

  assign w_in_valid   = {i_mem_valid, i_fpu_valid, i_alu_valid};
  assign w_in_rd[0]   = i_alu_rd;
  assign w_in_rd[1]   = i_fpu_rd;
  assign w_in_rd[2]   = i_mem_rd;
  assign w_in_data[0] = i_alu_data;
  assign w_in_data[1] = i_fpu_data;
  assign w_in_data[2] = i_mem_data;

  // Full is exactly the count MSB because BUF_DEPTH is a power of two
  always_comb begin
    for (int s = 0; s < NSRC; s++) begin
      w_ready[s]  = rstn & ~r_cnt[s][PW];
      w_push[s]   = w_in_valid[s] & w_ready[s] & (w_in_rd[s] != 5'd0);
      w_nempty[s] = (r_cnt[s] != '0);
    end
  end

  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt     = r_last;
    w_cand    = next_src(r_last);
    for (int k = 0; k < NSRC; k++) begin
      if (!w_gnt_vld && w_nempty[w_cand]) begin
        w_gnt_vld = 1'b1;
        w_gnt     = w_cand;
      end
      w_cand = next_src(w_cand);
    end
    for (int s = 0; s < NSRC; s++) begin
      w_pop[s] = w_gnt_vld & (w_gnt == 2'(s));
    end
  end

  always_comb begin
    w_pend = '0;
    for (int s = 0; s < NSRC; s++) begin
      for (int e = 0; e < BUF_DEPTH; e++) begin
        if (r_vld[s][e]) w_pend[r_rd[s][e]] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int s = 0; s < NSRC; s++) begin
        r_wptr[s] <= '0;
        r_rptr[s] <= '0;
        r_cnt[s]  <= '0;
        r_vld[s]  <= '0;
      end
      r_last     <= 2'd2;
      r_w_enable <= 1'b0;
      r_w_addr   <= 5'd0;
      r_w_data   <= 32'd0;
    end else begin
      for (int s = 0; s < NSRC; s++) begin
        if (w_push[s]) begin
          r_rd[s][r_wptr[s]]   <= w_in_rd[s];
          r_data[s][r_wptr[s]] <= w_in_data[s];
          r_vld[s][r_wptr[s]]  <= 1'b1;
          r_wptr[s]            <= r_wptr[s] + PW'(1);
        end
        if (w_pop[s]) begin
          r_vld[s][r_rptr[s]] <= 1'b0;
          r_rptr[s]           <= r_rptr[s] + PW'(1);
        end
        case ({w_push[s], w_pop[s]})
          2'b10:   r_cnt[s] <= r_cnt[s] + (PW+1)'(1);
          2'b01:   r_cnt[s] <= r_cnt[s] - (PW+1)'(1);
          default: r_cnt[s] <= r_cnt[s];
        endcase
      end
      r_w_enable <= w_gnt_vld;
      if (w_gnt_vld) begin
        r_w_addr <= r_rd[w_gnt][r_rptr[w_gnt]];
        r_w_data <= r_data[w_gnt][r_rptr[w_gnt]];
        r_last   <= w_gnt;
      end
    end
  end

  assign o_alu_ready = w_ready[0];
  assign o_fpu_ready = w_ready[1];
  assign o_mem_ready = w_ready[2];
  assign o_w_enable  = r_w_enable;
  assign o_w_addr    = r_w_addr;
  assign o_w_data    = r_w_data;
  // Entries still sit in the FIFO during reset, so the mask is gated explicitly
  assign o_pending   = rstn ? {w_pend[31:1], 1'b0} : 32'd0;

endmodule

// File: tb/tb_regf_writeback.sv
// Directed self-checking bench for regf_writeback with hand-computed expected write traces.
module tb_regf_writeback;

  logic        clk;
  logic        rstn;
  logic        alu_valid, fpu_valid, mem_valid;
  logic        alu_ready, fpu_ready, mem_ready;
  logic [4:0]  alu_rd, fpu_rd, mem_rd;
  logic [31:0] alu_data, fpu_data, mem_data;
  logic        w_enable;
  logic [4:0]  w_addr;
  logic [31:0] w_data;
  logic [31:0] pending;
  logic [2:0]  rdy;

  int n_cmp;
  int n_err;

  regf_writeback #(.BUF_DEPTH(2)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .i_alu_valid (alu_valid),
    .o_alu_ready (alu_ready),
    .i_alu_rd    (alu_rd),
    .i_alu_data  (alu_data),
    .i_fpu_valid (fpu_valid),
    .o_fpu_ready (fpu_ready),
    .i_fpu_rd    (fpu_rd),
    .i_fpu_data  (fpu_data),
    .i_mem_valid (mem_valid),
    .o_mem_ready (mem_ready),
    .i_mem_rd    (mem_rd),
    .i_mem_data  (mem_data),
    .o_w_enable  (w_enable),
    .o_w_addr    (w_addr),
    .o_w_data    (w_data),
    .o_pending   (pending)
  );

  assign rdy = {alu_ready, fpu_ready, mem_ready};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    alu_valid = 1'b0; fpu_valid = 1'b0; mem_valid = 1'b0;
    alu_rd = 5'd0; fpu_rd = 5'd0; mem_rd = 5'd0;
    alu_data = 32'd0; fpu_data = 32'd0; mem_data = 32'd0;
  endtask

  task automatic check_write(input string tag, input logic [4:0] addr, input logic [31:0] data);
    check_eq({tag, " en"}, 32'(w_enable), 32'd1);
    check_eq({tag, " addr"}, 32'(w_addr), 32'(addr));
    check_eq({tag, " data"}, w_data, data);
  endtask

  initial begin
    int ai, fi, mi, j, idx;
    logic xa, xf, xm;
    logic [2:0]  exp_rdy;
    logic [4:0]  exp_addr;
    logic [31:0] exp_data;
    n_cmp = 0;
    n_err = 0;
    idle_inputs();

    // Reset
    rstn = 1'b0;
    #1;
    check_eq("rst rdy pre", 32'(rdy), 32'd0);
    check_eq("rst pend pre", pending, 32'd0);
    tick();
    check_eq("rst en", 32'(w_enable), 32'd0);
    check_eq("rst addr", 32'(w_addr), 32'd0);
    check_eq("rst data", w_data, 32'd0);
    check_eq("rst rdy", 32'(rdy), 32'd0);
    tick();
    rstn = 1'b1;
    #1;
    check_eq("post rst rdy", 32'(rdy), 32'h7);

    // Three sources on the same edge: ALU first after reset, then FPU, then MEM
    alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'h1111_0001;
    fpu_valid = 1'b1; fpu_rd = 5'd2; fpu_data = 32'h2222_0002;
    mem_valid = 1'b1; mem_rd = 5'd3; mem_data = 32'h3333_0003;
    tick();
    idle_inputs();
    check_eq("t2 pend0", pending, 32'h0000_000E);
    check_eq("t2 en0", 32'(w_enable), 32'd0);
    tick();
    check_write("t2 w1", 5'd1, 32'h1111_0001);
    check_eq("t2 pend1", pending, 32'h0000_000C);
    tick();
    check_write("t2 w2", 5'd2, 32'h2222_0002);
    check_eq("t2 pend2", pending, 32'h0000_0008);
    tick();
    check_write("t2 w3", 5'd3, 32'h3333_0003);
    check_eq("t2 pend3", pending, 32'h0);
    tick();
    check_eq("t2 idle en", 32'(w_enable), 32'd0);

    // rd==0 is accepted and dropped
    mem_valid = 1'b1; mem_rd = 5'd0; mem_data = 32'h0000_1234;
    check_eq("t4 rdy", 32'(mem_ready), 32'd1);
    tick();
    idle_inputs();
    check_eq("t4 pend", pending, 32'h0);
    check_eq("t4 en0", 32'(w_enable), 32'd0);
    check_eq("t4 rdy after", 32'(mem_ready), 32'd1);
    tick();
    check_eq("t4 en1", 32'(w_enable), 32'd0);

    // Single ALU write
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEAD_BEEF;
    check_eq("t1 rdy", 32'(alu_ready), 32'd1);
    tick();
    idle_inputs();
    check_eq("t1 pend", pending, 32'h0000_0020);
    check_eq("t1 en0", 32'(w_enable), 32'd0);
    tick();
    check_write("t1 w", 5'd5, 32'hDEAD_BEEF);
    check_eq("t1 pend clr", pending, 32'h0);
    tick();
    check_eq("t1 en off", 32'(w_enable), 32'd0);
    check_eq("t1 addr hold", 32'(w_addr), 32'd5);
    check_eq("t1 data hold", w_data, 32'hDEAD_BEEF);

    // ALU FIFO fills while FPU and MEM win (last grant was ALU)
    alu_valid = 1'b1; alu_rd = 5'd10; alu_data = 32'hA10;
    fpu_valid = 1'b1; fpu_rd = 5'd20; fpu_data = 32'hF20;
    mem_valid = 1'b1; mem_rd = 5'd21; mem_data = 32'hC21;
    check_eq("t5 rdy0", 32'(rdy), 32'h7);
    tick();
    fpu_valid = 1'b0; mem_valid = 1'b0;
    alu_rd = 5'd11; alu_data = 32'hA11;
    check_eq("t5 pend1", pending, (32'h1 << 10) | (32'h1 << 20) | (32'h1 << 21));
    check_eq("t5 rdy1", 32'(alu_ready), 32'd1);
    tick();
    alu_rd = 5'd12; alu_data = 32'hA12;
    check_write("t5 w1", 5'd20, 32'hF20);
    check_eq("t5 full a", 32'(alu_ready), 32'd0);
    check_eq("t5 pend2", pending, (32'h1 << 10) | (32'h1 << 11) | (32'h1 << 21));
    tick();
    check_write("t5 w2", 5'd21, 32'hC21);
    check_eq("t5 full b", 32'(alu_ready), 32'd0);
    tick();
    check_write("t5 w3", 5'd10, 32'hA10);
    check_eq("t5 rdy back", 32'(alu_ready), 32'd1);
    tick();
    idle_inputs();
    check_write("t5 w4", 5'd11, 32'hA11);
    check_eq("t5 rdy4", 32'(alu_ready), 32'd1);
    check_eq("t5 pend4", pending, 32'h1 << 12);
    tick();
    check_write("t5 w5", 5'd12, 32'hA12);
    check_eq("t5 pend5", pending, 32'h0);
    tick();
    check_eq("t5 en end", 32'(w_enable), 32'd0);

    // All sources valid for 12 edges; writes rotate F,M,A starting after the last ALU grant
    ai = 0; fi = 0; mi = 0;
    for (int c = 1; c <= 18; c++) begin
      alu_valid = (c <= 12); fpu_valid = (c <= 12); mem_valid = (c <= 12);
      alu_rd = 5'(1 + ai);  alu_data = 32'hA000_0000 | 32'(ai);
      fpu_rd = 5'(8 + fi);  fpu_data = 32'hF000_0000 | 32'(fi);
      mem_rd = 5'(16 + mi); mem_data = 32'hC000_0000 | 32'(mi);
      xa = alu_valid & alu_ready;
      xf = fpu_valid & fpu_ready;
      xm = mem_valid & mem_ready;
      tick();
      if (xa) ai++;
      if (xf) fi++;
      if (xm) mi++;
      if (c == 1) begin
        check_eq("t3 rdy1", 32'(rdy), 32'h7);
      end else if (c <= 12) begin
        case ((c - 2) % 3)
          0:       exp_rdy = 3'b010;
          1:       exp_rdy = 3'b001;
          default: exp_rdy = 3'b100;
        endcase
        check_eq($sformatf("t3 rdy c%0d", c), 32'(rdy), 32'(exp_rdy));
      end
      if (c >= 2 && c <= 17) begin
        j = c - 2;
        idx = j / 3;
        case (j % 3)
          0: begin exp_addr = 5'(8 + idx);  exp_data = 32'hF000_0000 | 32'(idx); end
          1: begin exp_addr = 5'(16 + idx); exp_data = 32'hC000_0000 | 32'(idx); end
          default: begin exp_addr = 5'(1 + idx); exp_data = 32'hA000_0000 | 32'(idx); end
        endcase
        check_write($sformatf("t3 c%0d", c), exp_addr, exp_data);
      end else begin
        check_eq($sformatf("t3 en c%0d", c), 32'(w_enable), 32'd0);
      end
    end
    idle_inputs();

    // Reset with two entries buffered discards them
    alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h7777_0007;
    fpu_valid = 1'b1; fpu_rd = 5'd9; fpu_data = 32'h9999_0009;
    tick();
    idle_inputs();
    check_eq("t6 pend buf", pending, (32'h1 << 7) | (32'h1 << 9));
    rstn = 1'b0;
    #1;
    check_eq("t6 pend rst", pending, 32'h0);
    check_eq("t6 rdy rst", 32'(rdy), 32'd0);
    tick();
    check_eq("t6 en", 32'(w_enable), 32'd0);
    check_eq("t6 addr", 32'(w_addr), 32'd0);
    check_eq("t6 data", w_data, 32'd0);
    rstn = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      check_eq($sformatf("t6 no wr %0d", c), 32'(w_enable), 32'd0);
      check_eq($sformatf("t6 pend %0d", c), pending, 32'h0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
